seq_add64_cla16: RTL and testbench

Multi-cycle 64-bit adder that sits directly upstream of the existing combinational 16-bit CLA and drives it. It accepts one 64-bit operand pair plus carry-in per handshake and feeds one 16-bit slice per cycle through a single CLA_16bits instance, LSB slice first. The slice carry ripples through a register. The registered 65-bit result is presented with a valid/ready handshake.

---
 rtl/seq_add64_cla16_pkg.sv | 17 +
 rtl/seq_add64_cla16_cla.sv | 54 +++++
 rtl/seq_add64_cla16.sv | 137 +++++++++++++
 tb/tb_seq_add64_cla16.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seq_add64_cla16_pkg.sv
// Shared constants and FSM encoding for the sequential slice adder.
package seq_add64_cla16_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_CARRY = 1'b0;
    localparam logic   RST_COUT  = 1'b0;
    localparam logic   RST_OVF   = 1'b0;

endpackage

// File: rtl/seq_add64_cla16_cla.sv
// Combinational 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
// gp/gg are the slice-level propagate/generate, independent of cin.
module CLA_16bits (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        gp,
    output logic        gg
);

    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_c;
    logic [3:0]  w_bg;
    logic [3:0]  w_bp;
    logic [4:0]  w_bc;

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin
        w_bg = '0;
        w_bp = '0;
        w_bc = '0;
        w_c  = '0;
        for (int j = 0; j < 4; j++) begin
            w_bp[j] = &w_p[4*j +: 4];
            w_bg[j] = w_g[4*j+3]
                    | (w_p[4*j+3] & w_g[4*j+2])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
        end
        // Group carries come from lookahead, bit carries only ripple inside a group.
        w_bc[0] = cin;
        for (int j = 0; j < 4; j++) begin
            w_bc[j+1] = w_bg[j] | (w_bp[j] & w_bc[j]);
        end
        for (int j = 0; j < 4; j++) begin
            w_c[4*j] = w_bc[j];
            for (int i = 1; i < 4; i++) begin
                w_c[4*j+i] = w_g[4*j+i-1] | (w_p[4*j+i-1] & w_c[4*j+i-1]);
            end
        end
    end

    assign sum = w_p ^ w_c;
    assign gp  = &w_bp;
    assign gg  = w_bg[3]
               | (w_bp[3] & w_bg[2])
               | (w_bp[3] & w_bp[2] & w_bg[1])
               | (w_bp[3] & w_bp[2] & w_bp[1] & w_bg[0]);

endmodule

// File: rtl/seq_add64_cla16.sv
// Multi-cycle W-bit adder feeding one 16-bit slice per cycle through a shared CLA_16bits.
// Optional signed-overflow output enabled by defining SEQ_ADD_OVF_EN.
module seq_add64_cla16
    import seq_add64_cla16_pkg::*;
#(
    parameter int unsigned N_SLICES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SLICE_W*N_SLICES-1:0]   in_a,
    input  logic [SLICE_W*N_SLICES-1:0]   in_b,
    input  logic                          in_cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SLICE_W*N_SLICES-1:0]   sum,
`ifdef SEQ_ADD_OVF_EN
    output logic                          ovf,
`endif
    output logic                          cout
);

    localparam int unsigned CNT_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0]                  r_cnt;
    logic                              r_carry;
    logic                              r_cout;
    logic [N_SLICES-1:0][SLICE_W-1:0]  r_a;
    logic [N_SLICES-1:0][SLICE_W-1:0]  r_b;
    logic [N_SLICES-1:0][SLICE_W-1:0]  r_sum;

    logic [SLICE_W-1:0] w_a_slice;
    logic [SLICE_W-1:0] w_b_slice;
    logic [SLICE_W-1:0] w_sum_slice;
    logic               w_gp;
    logic               w_gg;
    logic               w_slice_cout;
    logic               w_last;

    assign w_a_slice    = r_a[r_cnt];
    assign w_b_slice    = r_b[r_cnt];
    assign w_slice_cout = w_gg | (w_gp & r_carry);
    assign w_last       = (r_cnt == CNT_W'(N_SLICES - 1));

    CLA_16bits u_cla (
        .a   (w_a_slice),
        .b   (w_b_slice),
        .cin (r_carry),
        .sum (w_sum_slice),
        .gp  (w_gp),
        .gg  (w_gg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_state_next = ADD;
            ADD:     if (w_last) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Operands need no reset: they are always loaded before being used.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && in_valid) begin
            r_a <= in_a;
            r_b <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_carry <= RST_CARRY;
            r_sum   <= '0;
            r_cout  <= RST_COUT;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_carry <= in_cin;
                        r_cnt   <= '0;
                    end
                end
                ADD: begin
                    r_sum[r_cnt] <= w_sum_slice;
                    r_carry      <= w_slice_cout;
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_cout <= w_slice_cout;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_ADD_OVF_EN
    logic r_ovf;

    // Carry into MSB xor carry out of MSB, recovered from the MSB sum bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= RST_OVF;
        end else if (r_state == ADD && w_last) begin
            r_ovf <= w_a_slice[SLICE_W-1] ^ w_b_slice[SLICE_W-1]
                   ^ w_sum_slice[SLICE_W-1] ^ w_slice_cout;
        end
    end

    assign ovf = r_ovf;
`endif

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_seq_add64_cla16.sv
// Scoreboard bench for seq_add64_cla16; also covers ovf when SEQ_ADD_OVF_EN is defined.
module tb_seq_add64_cla16;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
`ifdef SEQ_ADD_OVF_EN
    logic        ovf;
`endif

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        v;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_add64_cla16 #(.N_SLICES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef SEQ_ADD_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic ci);
        exp_t e;
        logic [64:0] full;
        full = {1'b0, a} + {1'b0, b} + {64'd0, ci};
        e.s = full[63:0];
        e.c = full[64];
        e.v = (a[63] == b[63]) && (full[63] != a[63]);
        return e;
    endfunction

    // Drives one operation, holds the result for hold cycles with a stray in_valid pulse,
    // then pops the scoreboard and compares.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic ci,
                         input int hold, input string tag);
        int   cyc;
        exp_t e;
        cyc = 0;
        @(negedge clk);
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_rdy"}, in_ready, 1'b1);
        in_a = a; in_b = b; in_cin = ci; in_valid = 1'b1;
        q.push_back(model(a, b, ci));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
        in_cin = 1'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq({tag, "_lat"}, cyc, N);
        e = q.pop_front();
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == 3 || i == 4);
            check_eq({tag, "_hold_v"}, out_valid, 1'b1);
            check_eq({tag, "_hold_s"}, {cout, sum}, {e.c, e.s});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_eq({tag, "_sum"}, sum, e.s);
        check_eq({tag, "_cout"}, cout, e.c);
`ifdef SEQ_ADD_OVF_EN
        check_eq({tag, "_ovf"}, ovf, e.v);
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_drop"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_sum", sum, 64'd0);
        check_eq("rst_cout", cout, 1'b0);
`ifdef SEQ_ADD_OVF_EN
        check_eq("rst_ovf", ovf, 1'b0);
`endif

        do_op(64'h1, 64'h2, 1'b1, 0, "basic");
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0, "ripple");
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, "max");
        do_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 0, "alt");
        do_op(64'hDEAD_BEEF_0123_4567, 64'h8000_0000_FFFF_0000, 1'b0, 10, "bp");
        // Stray in_valid during DONE must not have started a new operation.
        @(posedge clk);
        #1;
        check_eq("bp_ignored", {out_valid, in_ready}, 2'b01);

        // Abort on the 2nd ADD cycle.
        @(negedge clk);
        in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h1; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort_state", {out_valid, in_ready}, 2'b01);
        check_eq("abort_sum", {cout, sum}, 65'd0);
        do_op(64'h5, 64'h7, 1'b0, 0, "fresh");

        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, "ovf_pos");
        do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 0, "ovf_neg");

        for (int k = 0; k < 1000; k++) begin
            do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 0, "rand");
        end

        check_eq("sb_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
